lc3_decode_stage: RTL

// - Decode stage in front of the LC3 8x16 register file: accepts fetched IR/PC over valid/ready,

---
 rtl/lc3_pkg.sv | 32 +++
 rtl/lc3_scoreboard.sv | 48 ++++
 rtl/lc3_decode_stage.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared LC3 decode definitions: opcode encodings, immediate formats and the link register.
package lc3_pkg;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_RTI  = 4'b1000;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_RES  = 4'b1101;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   localparam logic [2:0] REG_LINK = 3'd7;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_5,
      IMM_6,
      IMM_9,
      IMM_11,
      IMM_TRAP8
   } imm_fmt_e;

endpackage

// File: rtl/lc3_scoreboard.sv
// Pending-write mask for the decode stage; flags a RAW hazard on the incoming instruction's sources.
module lc3_scoreboard
   import lc3_pkg::*;
#(
   parameter int NREGS = 8,
   parameter int REG_W = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en,
   input  logic [REG_W-1:0] set_reg,
   input  logic             clr_en,
   input  logic [REG_W-1:0] clr_reg,
   input  logic             busy_en,
   input  logic [REG_W-1:0] busy_reg,
   input  logic             chk_en,
   input  logic [REG_W-1:0] src1,
   input  logic             src1_use,
   input  logic [REG_W-1:0] src2,
   input  logic             src2_use,
   output logic             hazard,
   output logic [NREGS-1:0] pending
);

   logic [NREGS-1:0] pending_next;
   logic             hit1;
   logic             hit2;

   // Set is applied after clear so a same-cycle set/clear of one register leaves it pending.
   always_comb begin
      pending_next = pending;
      if (clr_en) pending_next[clr_reg] = 1'b0;
      if (set_en) pending_next[set_reg] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= pending_next;
   end

   // A retiring write is forwarded by the register file, but the held bundle's write is still ahead.
   always_comb begin
      hit1 = (pending[src1] & ~(clr_en & (clr_reg == src1))) | (busy_en & (busy_reg == src1));
      hit2 = (pending[src2] & ~(clr_en & (clr_reg == src2))) | (busy_en & (busy_reg == src2));
      hazard = chk_en & ((src1_use & hit1) | (src2_use & hit2));
   end

endmodule

// File: rtl/lc3_decode_stage.sv
// LC3 decode stage: valid/ready bundle register aligned with register-file reads.
// Optional RAW interlock enabled by defining LC3_DEC_SCOREBOARD_EN.
module lc3_decode_stage
   import lc3_pkg::*;
#(
   parameter int PC_W  = 16,
   parameter int NREGS = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       IR_VALID,
   output logic                       IR_READY,
   input  logic [15:0]                IR,
   input  logic [PC_W-1:0]            PC_IN,
   output logic [$clog2(NREGS)-1:0]   RS1,
   output logic [$clog2(NREGS)-1:0]   RS2,
   output logic                       DEC_VALID,
   input  logic                       DEC_READY,
   output logic [3:0]                 OPCODE,
   output logic [$clog2(NREGS)-1:0]   DR,
   output logic                       WB_EN,
   output logic [PC_W-1:0]            IMM,
   output logic                       USE_IMM,
   output logic                       SETCC,
   output logic                       ILLEGAL,
   output logic [PC_W-1:0]            PC_OUT,
   input  logic                       WB_DONE,
   input  logic [$clog2(NREGS)-1:0]   WB_DR
);

   localparam int REG_W = $clog2(NREGS);

   function automatic logic signed [PC_W-1:0] build_imm(input imm_fmt_e fmt, input logic [10:0] f);
      case (fmt)
         IMM_5:     build_imm = PC_W'($signed(f[4:0]));
         IMM_6:     build_imm = PC_W'($signed(f[5:0]));
         IMM_9:     build_imm = PC_W'($signed(f[8:0]));
         IMM_11:    build_imm = PC_W'($signed(f[10:0]));
         IMM_TRAP8: build_imm = PC_W'(f[7:0]);
         default:   build_imm = '0;
      endcase
   endfunction

   logic [3:0]              opc_p0;
   logic [REG_W-1:0]        dr_p0;
   logic [REG_W-1:0]        rs2_p0;
   logic                    wb_en_p0;
   logic                    setcc_p0;
   logic                    use_imm_p0;
   logic                    illegal_p0;
   logic                    src1_use;
   logic                    src2_use;
   imm_fmt_e                fmt_p0;
   logic signed [PC_W-1:0]  imm_p0;

   logic                    vld_p1;
   logic [3:0]              opc_p1;
   logic [REG_W-1:0]        dr_p1;
   logic [REG_W-1:0]        rs1_p1;
   logic [REG_W-1:0]        rs2_p1;
   logic                    wb_en_p1;
   logic                    setcc_p1;
   logic                    use_imm_p1;
   logic                    illegal_p1;
   logic signed [PC_W-1:0]  imm_p1;
   logic [PC_W-1:0]         pc_p1;

   logic                    hazard;
   logic                    accept;
   logic                    handoff;

   // Stage p0: combinational decode of the incoming instruction word.
   always_comb begin
      opc_p0     = IR[15:12];
      dr_p0      = IR[11:9];
      rs2_p0     = '0;
      wb_en_p0   = 1'b0;
      setcc_p0   = 1'b0;
      use_imm_p0 = 1'b0;
      illegal_p0 = 1'b0;
      src1_use   = 1'b0;
      src2_use   = 1'b0;
      fmt_p0     = IMM_NONE;
      case (opc_p0)
         OP_ADD, OP_AND: begin
            wb_en_p0   = 1'b1;
            setcc_p0   = 1'b1;
            use_imm_p0 = IR[5];
            fmt_p0     = IR[5] ? IMM_5 : IMM_NONE;
            rs2_p0     = IR[2:0];
            src1_use   = 1'b1;
            src2_use   = ~IR[5];
         end
         OP_NOT: begin
            wb_en_p0 = 1'b1;
            setcc_p0 = 1'b1;
            src1_use = 1'b1;
         end
         OP_LD, OP_LDI, OP_LEA: begin
            wb_en_p0 = 1'b1;
            setcc_p0 = 1'b1;
            fmt_p0   = IMM_9;
         end
         OP_LDR: begin
            wb_en_p0 = 1'b1;
            setcc_p0 = 1'b1;
            fmt_p0   = IMM_6;
            src1_use = 1'b1;
         end
         OP_ST, OP_STI: begin
            fmt_p0   = IMM_9;
            rs2_p0   = IR[11:9];
            src2_use = 1'b1;
         end
         OP_STR: begin
            fmt_p0   = IMM_6;
            rs2_p0   = IR[11:9];
            src1_use = 1'b1;
            src2_use = 1'b1;
         end
         OP_BR:  fmt_p0 = IMM_9;
         OP_JMP: src1_use = 1'b1;
         OP_JSR: begin
            dr_p0    = REG_LINK;
            wb_en_p0 = 1'b1;
            fmt_p0   = IR[11] ? IMM_11 : IMM_NONE;
            src1_use = ~IR[11];
         end
         OP_TRAP: begin
            dr_p0    = REG_LINK;
            wb_en_p0 = 1'b1;
            fmt_p0   = IMM_TRAP8;
         end
         OP_RTI, OP_RES: illegal_p0 = 1'b1;
      endcase
      imm_p0 = build_imm(fmt_p0, IR[10:0]);
   end

   assign IR_READY = (~vld_p1 | DEC_READY) & ~hazard;
   assign accept   = IR_VALID & IR_READY;
   assign handoff  = vld_p1 & DEC_READY;

   // Re-select the held instruction's sources while stalled so read data follows retiring writes.
   assign RS1 = accept ? IR[8:6] : rs1_p1;
   assign RS2 = accept ? rs2_p0  : rs2_p1;

   // Stage p1: bundle register, aligned with register-file DATA_OUT1/2.
   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_p1     <= 1'b0;
         opc_p1     <= '0;
         dr_p1      <= '0;
         rs1_p1     <= '0;
         rs2_p1     <= '0;
         wb_en_p1   <= 1'b0;
         setcc_p1   <= 1'b0;
         use_imm_p1 <= 1'b0;
         illegal_p1 <= 1'b0;
         imm_p1     <= '0;
         pc_p1      <= '0;
      end else if (accept) begin
         vld_p1     <= 1'b1;
         opc_p1     <= opc_p0;
         dr_p1      <= dr_p0;
         rs1_p1     <= IR[8:6];
         rs2_p1     <= rs2_p0;
         wb_en_p1   <= wb_en_p0;
         setcc_p1   <= setcc_p0;
         use_imm_p1 <= use_imm_p0;
         illegal_p1 <= illegal_p0;
         imm_p1     <= imm_p0;
         pc_p1      <= PC_IN;
      end else if (DEC_READY) begin
         vld_p1 <= 1'b0;
      end
   end

   assign DEC_VALID = vld_p1;
   assign OPCODE    = opc_p1;
   assign DR        = dr_p1;
   assign WB_EN     = wb_en_p1;
   assign IMM       = imm_p1;
   assign USE_IMM   = use_imm_p1;
   assign SETCC     = setcc_p1;
   assign ILLEGAL   = illegal_p1;
   assign PC_OUT    = pc_p1;

`ifdef LC3_DEC_SCOREBOARD_EN
   logic [NREGS-1:0] pending;

   lc3_scoreboard #(
      .NREGS (NREGS),
      .REG_W (REG_W)
   ) u_sb (
      .clk      (CLK),
      .rst      (RST),
      .set_en   (handoff & wb_en_p1),
      .set_reg  (dr_p1),
      .clr_en   (WB_DONE),
      .clr_reg  (WB_DR),
      .busy_en  (vld_p1 & wb_en_p1),
      .busy_reg (dr_p1),
      .chk_en   (IR_VALID),
      .src1     (IR[8:6]),
      .src1_use (src1_use),
      .src2     (rs2_p0),
      .src2_use (src2_use),
      .hazard   (hazard),
      .pending  (pending)
   );
`else
   logic unused_sb;

   // Without the interlock, software schedules around in-flight writes.
   assign hazard    = 1'b0;
   assign unused_sb = ^{WB_DONE, WB_DR, src1_use, src2_use, handoff};
`endif

endmodule
